// File: rtl/n64_vdemux_pkg.sv
// Shared definitions for the N64 video demultiplexer: sync bit positions, lock states,
// and line-counter sizing.
package n64_vdemux_pkg;

   localparam int SYNC_VS    = 3;
   localparam int SYNC_CLAMP = 2;
   localparam int SYNC_HS    = 1;
   localparam int SYNC_CS    = 0;

   localparam int                    LINE_CNT_W          = 10;
   localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX        = '1;
   localparam logic [LINE_CNT_W-1:0] PAL_LINE_THRESH_DEF = 10'd300;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   typedef logic [3:0] sync_t;

   // Active-low sync lines: a "fall" is the edge into the asserted state.
   function automatic logic falling(input logic prev_b, input logic new_b);
      return prev_b & ~new_b;
   endfunction

endpackage

// File: rtl/n64_mode_detect.sv
// Field-length based PAL / interlace detection on demuxed sync words.
// Flags update one cycle after a strobe; no backpressure (strobe-driven).
module n64_mode_detect
   import n64_vdemux_pkg::*;
#(
   parameter logic [LINE_CNT_W-1:0] pal_line_thresh = PAL_LINE_THRESH_DEF
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  strobe,
   input  sync_t sync,
   output logic  palmode,
   output logic  interlaced,
   output logic  mode_valid
);

   sync_t                 prev_sync;
   logic [LINE_CNT_W-1:0] line_cnt;
   logic [LINE_CNT_W-1:0] prev_line_cnt;
   logic                  have_prev;
   logic [1:0]            good_cnt;

   logic sync_chg;
   logic hs_fall;
   logic vs_fall;
   logic line_sat;

   // Edges can only occur when the word differs, so the history register
   // only needs to load on a changed strobe.
   assign sync_chg = strobe && (sync != prev_sync);
   assign hs_fall  = sync_chg && falling(prev_sync[SYNC_HS], sync[SYNC_HS]);
   assign vs_fall  = sync_chg && falling(prev_sync[SYNC_VS], sync[SYNC_VS]);
   assign line_sat = (line_cnt == LINE_CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_sync     <= 4'hF;
         line_cnt      <= '0;
         prev_line_cnt <= '0;
         have_prev     <= 1'b0;
         good_cnt      <= 2'd0;
         palmode       <= 1'b0;
         interlaced    <= 1'b0;
         mode_valid    <= 1'b0;
      end else begin
         if (sync_chg) begin
            prev_sync <= sync;
         end
         if (vs_fall) begin
            prev_line_cnt <= line_cnt;
            have_prev     <= 1'b1;
            line_cnt      <= LINE_CNT_W'(hs_fall);
            if (line_sat) begin
               // Runaway field: distrust the mode until two clean fields follow.
               good_cnt   <= 2'd0;
               mode_valid <= 1'b0;
            end else begin
               palmode <= (line_cnt > pal_line_thresh);
               if (have_prev) begin
                  interlaced <= (line_cnt != prev_line_cnt);
               end
               if (good_cnt != 2'd2) begin
                  good_cnt <= good_cnt + 2'd1;
               end
               mode_valid <= (good_cnt != 2'd0);
            end
         end else if (hs_fall && !line_sat) begin
            line_cnt <= line_cnt + LINE_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/n64_vdemux_vinfo.sv
// Demuxes the 4-phase N64 video bus into sync/R/G/B with a pixel strobe and mode info.
// Strobe 1 cycle after the B sample; no backpressure, phase errors resync and are counted.
module n64_vdemux_vinfo
   import n64_vdemux_pkg::*;
#(
   parameter int                    color_width_i    = 7,
   parameter logic [LINE_CNT_W-1:0] pal_line_thresh  = PAL_LINE_THRESH_DEF,
   parameter int                    resync_cnt_width = 8
) (
   input  logic                        N64_CLK_i,
   input  logic                        N64_nVRST_i,
   input  logic                        nVDSYNC_i,
   input  logic [color_width_i-1:0]    VD_i,
   output logic                        vdata_valid_o,
   output logic [3:0]                  vdata_sync_o,
   output logic [color_width_i-1:0]    vdata_r_o,
   output logic [color_width_i-1:0]    vdata_g_o,
   output logic [color_width_i-1:0]    vdata_b_o,
   output logic                        palmode_o,
   output logic                        interlaced_o,
   output logic                        mode_valid_o,
   output logic [resync_cnt_width-1:0] resync_cnt_o
);

   lock_state_t state_q;
   lock_state_t state_nxt;
   logic [1:0]  phase_q;
   logic [1:0]  phase_nxt;

   logic cap_sync;
   logic cap_r;
   logic cap_g;
   logic pix_done;
   logic phase_err;

   sync_t                    sync_q;
   logic [color_width_i-1:0] r_q;
   logic [color_width_i-1:0] g_q;

   always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
      if (!N64_nVRST_i) begin
         state_q <= UNLOCKED;
         phase_q <= 2'd0;
      end else begin
         state_q <= state_nxt;
         phase_q <= phase_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      phase_nxt = phase_q;
      cap_sync  = 1'b0;
      cap_r     = 1'b0;
      cap_g     = 1'b0;
      pix_done  = 1'b0;
      phase_err = 1'b0;
      unique case (state_q)
         UNLOCKED: begin
            phase_nxt = 2'd0;
            if (!nVDSYNC_i) begin
               cap_sync  = 1'b1;
               state_nxt = LOCKED;
               phase_nxt = 2'd1;
            end
         end
         LOCKED: begin
            if (!nVDSYNC_i) begin
               // Sync always restarts the pixel; early sync drops the partial one.
               cap_sync  = 1'b1;
               phase_err = (phase_q != 2'd0);
               phase_nxt = 2'd1;
            end else if (phase_q == 2'd0) begin
               phase_err = 1'b1;
               state_nxt = UNLOCKED;
               phase_nxt = 2'd0;
            end else begin
               phase_nxt = phase_q + 2'd1;
               cap_r     = (phase_q == 2'd1);
               cap_g     = (phase_q == 2'd2);
               pix_done  = (phase_q == 2'd3);
            end
         end
         default: begin
            state_nxt = UNLOCKED;
            phase_nxt = 2'd0;
         end
      endcase
   end

   always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
      if (!N64_nVRST_i) begin
         sync_q        <= 4'hF;
         r_q           <= '0;
         g_q           <= '0;
         vdata_valid_o <= 1'b0;
         vdata_sync_o  <= 4'hF;
         vdata_r_o     <= '0;
         vdata_g_o     <= '0;
         vdata_b_o     <= '0;
      end else begin
         if (cap_sync) sync_q <= VD_i[3:0];
         if (cap_r)    r_q    <= VD_i;
         if (cap_g)    g_q    <= VD_i;
         vdata_valid_o <= pix_done;
         // B goes straight to the output so the pixel appears one cycle after its last phase.
         if (pix_done) begin
            vdata_sync_o <= sync_q;
            vdata_r_o    <= r_q;
            vdata_g_o    <= g_q;
            vdata_b_o    <= VD_i;
         end
      end
   end

   always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
      if (!N64_nVRST_i) begin
         resync_cnt_o <= '0;
      end else if (phase_err && (resync_cnt_o != {resync_cnt_width{1'b1}})) begin
         resync_cnt_o <= resync_cnt_o + resync_cnt_width'(1);
      end
   end

   n64_mode_detect #(
      .pal_line_thresh(pal_line_thresh)
   ) u_mode_detect (
      .clk       (N64_CLK_i),
      .rst_n     (N64_nVRST_i),
      .strobe    (vdata_valid_o),
      .sync      (vdata_sync_o),
      .palmode   (palmode_o),
      .interlaced(interlaced_o),
      .mode_valid(mode_valid_o)
   );

endmodule

// File: tb/tb_n64_vdemux_vinfo.sv
// Bench for n64_vdemux_vinfo: pixel-assembly / field-length reference model compared every cycle,
// plus directed literal checks on lock, resync, mode detection and async reset.
module tb_n64_vdemux_vinfo;

   localparam int CW   = 7;
   localparam int RW   = 8;
   localparam int RMAX = (1 << RW) - 1;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          nvd   = 1'b1;
   logic [CW-1:0] vd    = '0;

   logic          vdata_valid;
   logic [3:0]    vdata_sync;
   logic [CW-1:0] vdata_r;
   logic [CW-1:0] vdata_g;
   logic [CW-1:0] vdata_b;
   logic          palmode;
   logic          interlaced;
   logic          mode_valid;
   logic [RW-1:0] resync_cnt;

   always #5 clk = ~clk;

   n64_vdemux_vinfo #(
      .color_width_i   (CW),
      .pal_line_thresh (10'd300),
      .resync_cnt_width(RW)
   ) dut (
      .N64_CLK_i    (clk),
      .N64_nVRST_i  (rst_n),
      .nVDSYNC_i    (nvd),
      .VD_i         (vd),
      .vdata_valid_o(vdata_valid),
      .vdata_sync_o (vdata_sync),
      .vdata_r_o    (vdata_r),
      .vdata_g_o    (vdata_g),
      .vdata_b_o    (vdata_b),
      .palmode_o    (palmode),
      .interlaced_o (interlaced),
      .mode_valid_o (mode_valid),
      .resync_cnt_o (resync_cnt)
   );

   int checks  = 0;
   int errors  = 0;
   bit started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pixel side: samples collected since the last sync-low cycle (0 = not locked,
   // 4 = complete pixel waiting for the next sync).
   logic [CW-1:0] samp [4];
   int            pix_len;
   int            err_cnt;
   logic          exp_valid;
   logic [3:0]    exp_sync;
   logic [CW-1:0] exp_r, exp_g, exp_b;
   // Mode side: field lengths between VS falls.
   logic [3:0]    m_prev;
   int            m_lines;
   int            m_good;
   int            fields[$];
   logic          exp_pal, exp_int, exp_mv;

   task automatic bump_err();
      if (err_cnt < RMAX) err_cnt++;
   endtask

   task automatic mode_step(input logic [3:0] s);
      bit hs_f, vs_f;
      hs_f = m_prev[1] && !s[1];
      vs_f = m_prev[3] && !s[3];
      if (vs_f) begin
         if (m_lines < 1023) begin
            exp_pal = (m_lines > 300);
            if (fields.size() > 0) exp_int = (m_lines != fields[$]);
            m_good++;
            exp_mv = (m_good >= 2);
         end else begin
            m_good = 0;
            exp_mv = 1'b0;
         end
         fields.push_back(m_lines);
         m_lines = hs_f ? 1 : 0;
      end else if (hs_f && m_lines < 1023) begin
         m_lines++;
      end
      m_prev = s;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_len   = 0;
         err_cnt   = 0;
         exp_valid = 1'b0;
         exp_sync  = 4'hF;
         exp_r     = '0;
         exp_g     = '0;
         exp_b     = '0;
         m_prev    = 4'hF;
         m_lines   = 0;
         m_good    = 0;
         exp_pal   = 1'b0;
         exp_int   = 1'b0;
         exp_mv    = 1'b0;
         fields.delete();
      end else begin
         if (exp_valid) mode_step(exp_sync);
         exp_valid = 1'b0;
         if (!nvd) begin
            if (pix_len >= 1 && pix_len <= 3) bump_err();
            samp[0] = vd;
            pix_len = 1;
         end else if (pix_len == 4) begin
            bump_err();
            pix_len = 0;
         end else if (pix_len >= 1) begin
            samp[pix_len] = vd;
            pix_len++;
            if (pix_len == 4) begin
               exp_valid = 1'b1;
               exp_sync  = samp[0][3:0];
               exp_r     = samp[1];
               exp_g     = samp[2];
               exp_b     = samp[3];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("valid",      {31'd0, vdata_valid}, {31'd0, exp_valid});
         check("sync",       {28'd0, vdata_sync},  {28'd0, exp_sync});
         check("red",        32'(vdata_r),         32'(exp_r));
         check("green",      32'(vdata_g),         32'(exp_g));
         check("blue",       32'(vdata_b),         32'(exp_b));
         check("palmode",    {31'd0, palmode},     {31'd0, exp_pal});
         check("interlaced", {31'd0, interlaced},  {31'd0, exp_int});
         check("mode_valid", {31'd0, mode_valid},  {31'd0, exp_mv});
         check("resync_cnt", 32'(resync_cnt),      32'(err_cnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic n, input logic [CW-1:0] v);
      @(negedge clk);
      nvd = n;
      vd  = v;
   endtask

   task automatic pixel(input logic [3:0] s, input logic [CW-1:0] r, input logic [CW-1:0] g,
                        input logic [CW-1:0] b);
      drive(1'b0, CW'(s));
      drive(1'b1, r);
      drive(1'b1, g);
      drive(1'b1, b);
   endtask

   task automatic rnd_pixel(input logic [3:0] s);
      pixel(s, CW'($urandom_range(0, 127)), CW'($urandom_range(0, 127)),
            CW'($urandom_range(0, 127)));
   endtask

   // n lines (each one HS fall) followed by a VS-asserted pixel.
   task automatic field(input int n);
      for (int i = 0; i < n; i++) begin
         rnd_pixel(4'hF);
         rnd_pixel(4'hD);
      end
      rnd_pixel(4'h7);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid"},  {31'd0, vdata_valid}, 32'd0);
      check({tag, "_sync"},   {28'd0, vdata_sync},  32'hF);
      check({tag, "_red"},    32'(vdata_r),         32'd0);
      check({tag, "_blue"},   32'(vdata_b),         32'd0);
      check({tag, "_pal"},    {31'd0, palmode},     32'd0);
      check({tag, "_int"},    {31'd0, interlaced},  32'd0);
      check({tag, "_mv"},     {31'd0, mode_valid},  32'd0);
      check({tag, "_resync"}, 32'(resync_cnt),      32'd0);
   endtask

   initial begin
      int gp;
      logic n;
      #2 rst_n = 1'b0;
      started = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle: no sync at all.
      repeat (20) drive(1'b1, 7'h0F);
      check_reset_vals("idle");

      // Well-formed pixels.
      repeat (5) pixel(4'hF, 7'h12, 7'h34, 7'h56);
      drive(1'b0, 7'h0F);
      check("px_valid", {31'd0, vdata_valid}, 32'd1);
      check("px_sync",  {28'd0, vdata_sync},  32'hF);
      check("px_r",     32'(vdata_r),         32'h12);
      check("px_g",     32'(vdata_g),         32'h34);
      check("px_b",     32'(vdata_b),         32'h56);
      drive(1'b1, 7'h12);
      drive(1'b1, 7'h34);
      drive(1'b1, 7'h56);

      // Early sync at phase 2.
      drive(1'b0, 7'h0F);
      drive(1'b1, 7'h12);
      drive(1'b0, 7'h0F);
      drive(1'b1, 7'h21);
      drive(1'b1, 7'h43);
      drive(1'b1, 7'h65);
      drive(1'b0, 7'h0F);
      check("err1_resync", 32'(resync_cnt),      32'd1);
      check("err1_valid",  {31'd0, vdata_valid}, 32'd1);
      check("err1_r",      32'(vdata_r),         32'h21);
      drive(1'b1, 7'h12);
      drive(1'b1, 7'h34);
      drive(1'b1, 7'h56);
      repeat (300) begin
         drive(1'b0, 7'h0F);
         drive(1'b1, 7'h12);
      end
      drive(1'b0, 7'h0F);
      drive(1'b1, 7'h12);
      drive(1'b1, 7'h34);
      drive(1'b1, 7'h56);
      drive(1'b0, 7'h0F);
      check("err_sat", 32'(resync_cnt), 32'd255);
      drive(1'b1, 7'h12);
      drive(1'b1, 7'h34);
      drive(1'b1, 7'h56);

      // Missing sync at phase 0: unlock, pixel-shaped data must not strobe.
      drive(1'b1, 7'h0F);
      drive(1'b1, 7'h11);
      drive(1'b1, 7'h22);
      drive(1'b1, 7'h33);
      drive(1'b1, 7'h0F);
      check("unlock_valid", {31'd0, vdata_valid}, 32'd0);
      check("unlock_b",     32'(vdata_b),         32'h56);
      pixel(4'hF, 7'h01, 7'h02, 7'h03);
      drive(1'b0, 7'h0F);
      check("relock_valid", {31'd0, vdata_valid}, 32'd1);
      check("relock_b",     32'(vdata_b),         32'h03);
      drive(1'b1, 7'h00);
      drive(1'b1, 7'h00);
      drive(1'b1, 7'h00);

      // Randomised traffic: mostly well-phased, occasional phase errors.
      gp = 0;
      for (int i = 0; i < 2000; i++) begin
         n = (gp == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 39) == 0) n = ~n;
         drive(n, CW'($urandom_range(0, 127)));
         gp = (gp + 1) % 4;
      end

      // Asynchronous reset between edges.
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_vals("arst1");
      @(negedge clk);
      rst_n = 1'b1;

      // NTSC progressive fields.
      field(263);
      rnd_pixel(4'hF);
      check("f1_mv", {31'd0, mode_valid}, 32'd0);
      field(263);
      rnd_pixel(4'hF);
      check("f2_mv",  {31'd0, mode_valid}, 32'd1);
      check("f2_pal", {31'd0, palmode},    32'd0);
      check("f2_int", {31'd0, interlaced}, 32'd0);
      field(263);

      // PAL interlaced fields.
      field(312);
      rnd_pixel(4'hF);
      field(313);
      rnd_pixel(4'hF);
      check("pal_mv",  {31'd0, mode_valid}, 32'd1);
      check("pal_pal", {31'd0, palmode},    32'd1);
      check("pal_int", {31'd0, interlaced}, 32'd1);

      // Runaway field saturates the line counter.
      field(1100);
      rnd_pixel(4'hF);
      check("sat_mv",  {31'd0, mode_valid}, 32'd0);
      check("sat_pal", {31'd0, palmode},    32'd1);
      check("sat_int", {31'd0, interlaced}, 32'd1);
      field(263);
      rnd_pixel(4'hF);
      check("rec1_mv", {31'd0, mode_valid}, 32'd0);
      field(263);
      rnd_pixel(4'hF);
      check("rec2_mv",  {31'd0, mode_valid}, 32'd1);
      check("rec2_pal", {31'd0, palmode},    32'd0);
      check("rec2_int", {31'd0, interlaced}, 32'd0);

      // Reset in the middle of a field and mid-pixel.
      repeat (50) begin
         rnd_pixel(4'hF);
         rnd_pixel(4'hD);
      end
      drive(1'b0, 7'h0F);
      drive(1'b1, 7'h12);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_vals("arst2");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) drive(1'b1, 7'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
